// File: rtl/mult_repeated_add_if.sv
// Operand/result bus of the repeated-addition multiplier.
// The master issues start and drives both operands; the slave returns the product with done/busy.
interface mult_repeated_add_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [WIDTH-1:0]     data_in;
    logic [2*WIDTH-1:0]   product;
    logic                 done;
    logic                 busy;

    modport master (
        output start,
        output data_in,
        input  product,
        input  done,
        input  busy
    );

    modport slave (
        input  start,
        input  data_in,
        output product,
        output done,
        output busy
    );
endinterface

// File: rtl/mult_repeated_add.sv
// Sequential unsigned multiplier: adds the larger operand once per unit of the smaller one.
//
// state  | meaning
// IDLE   | waiting for start, product holds
// LOAD_A | capture operand A from data_in, clear product
// LOAD_B | take B from data_in, load addend=max and counter=min
// CALC   | one add per cycle until counter reaches zero
// DONE   | product valid and frozen, start relaunches
module mult_repeated_add #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_repeated_add_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CALC   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     counter;
    logic [2*WIDTH-1:0]   product_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = LOAD_A;
            LOAD_A:  state_next = LOAD_B;
            LOAD_B:  state_next = CALC;
            CALC:    if (counter == '0) state_next = DONE;
            DONE:    if (bus.start) state_next = LOAD_A;
            default: state_next = IDLE;
        endcase
    end

    // B is used straight off the bus so the swap costs no extra cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg     <= '0;
            addend    <= '0;
            counter   <= '0;
            product_q <= '0;
        end else begin
            case (state)
                LOAD_A: begin
                    a_reg     <= bus.data_in;
                    product_q <= '0;
                end
                LOAD_B: begin
                    if (a_reg >= bus.data_in) begin
                        addend  <= a_reg;
                        counter <= bus.data_in;
                    end else begin
                        addend  <= bus.data_in;
                        counter <= a_reg;
                    end
                end
                CALC: begin
                    if (counter != '0) begin
                        product_q <= product_q + {{WIDTH{1'b0}}, addend};
                        counter   <= counter - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.product = product_q;
    assign bus.done    = (state == DONE);
    assign bus.busy    = (state == LOAD_A) || (state == LOAD_B) || (state == CALC);

endmodule

// File: doc/mult_repeated_add.md
Name: mult_repeated_add

Overview:
- Sequential unsigned multiplier using repeated addition; the inverse of the team's repeated-subtraction divider.
- Takes both operands over one shared input bus in consecutive cycles after start, then adds the larger operand into an accumulator once per unit of the smaller operand.
- Datapath and control live in one module: operand registers, compare/swap, down-counter, accumulator, FSM.
- Used by the arithmetic test system wherever a product is needed, including checking divider results (quotient*divisor).

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request a new multiply; honoured only in IDLE or DONE
data_in  input  WIDTH  shared operand bus: operand A one cycle after start, operand B the next cycle
product  output  2*WIDTH  registered accumulator; final A*B valid while done=1
done  output  1  high while in DONE state
busy  output  1  high in LOAD_A, LOAD_B, CALC

Behaviour:
- Reset (rst_n=0 at clk edge, overrides everything): state=IDLE; product=0, done=0, busy=0; internal addend, counter, A register = 0.
- States: IDLE, LOAD_A, LOAD_B, CALC, DONE. Register encoding is free.
- IDLE: if start=1, next=LOAD_A; product holds.
- LOAD_A (busy=1): capture data_in into A register; product cleared to 0; next=LOAD_B.
- LOAD_B (busy=1): B=data_in, used directly (not registered first).
  - Compare A with B: addend <= max(A,B); counter <= min(A,B); if equal, addend=A and counter=B.
  - next=CALC.
- CALC (busy=1): if counter==0, next=DONE with no add. Else product <= product + zero_extend(addend), counter <= counter-1, stay in CALC.
- DONE: done=1, busy=0, product frozen. start=1 gives next=LOAD_A (back-to-back operation); else stay in DONE.
- start is ignored in LOAD_A, LOAD_B and CALC. data_in is don't-care except in LOAD_A and LOAD_B.
- Latency: with start sampled high at the end of cycle 0, A is sampled at the end of cycle 1 and B at the end of cycle 2.
  - CALC occupies cycles 3 .. 3+min(A,B).
  - done first high in cycle 4+min(A,B).
  - Worst case 4+(2^WIDTH-1).
- Arithmetic: unsigned. Accumulator is 2*WIDTH bits; max product (2^WIDTH-1)^2 fits, so no overflow and no wrap. Counter is WIDTH bits and never decrements below 0.
- Zero operand: counter=0, one CALC cycle, DONE with product=0.
- Reset mid-operation: returns to IDLE next edge, clears product/done/busy. Operation is aborted and a fresh start is required.
- Outputs are purely registered state or decoded from the state register; no combinational path from inputs to outputs.

Test Plan:
- Reset for 2 cycles, start=1 in cycle 0, data_in=3 (cycle 1), 5 (cycle 2) -> busy cycles 1..6; done=1 from cycle 7; product=15 (0x0000000F); exactly 3 add cycles.
- A=0, B=0x1234 -> done in cycle 4, product=0. Then A=0x1234, B=0 -> same.
- A=2, B=0xFFFF -> swap makes counter=2; done in cycle 6; product=0x0001FFFE. A=0x0100, B=0x0100 -> done in cycle 260, product=0x00010000.
- start pulsed during CALC and data_in toggled randomly -> ignored; result and latency unchanged. From DONE, start with 7 and 6 -> product cleared in LOAD_A; done drops in cycle 1; done returns in cycle 10 with 42.
- rst_n=0 for one cycle mid-CALC (A=100, B=50) -> next cycle IDLE, product=0, done=0, busy=0. Later start with 4 and 4 -> 16 with normal latency.
- Randomised regression (WIDTH=16, plus one run at WIDTH=8 exhaustive) vs reference model A*B; latency must equal 4+min(A,B).
